// File: rtl/tx_agc_pkg.sv
// Shared types and constants for the transmit AGC / limiter.
package tx_agc_pkg;

  localparam int WIDTH     = 24;
  localparam int GAIN_W    = 16;
  localparam int GAIN_FRAC = 12;

  typedef logic signed [WIDTH-1:0] sample_t;
  typedef logic [GAIN_W-1:0]       gain_t;

  localparam gain_t GAIN_UNITY = gain_t'(1 << GAIN_FRAC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPT,
    ST_MUL,
    ST_SAT,
    ST_ADJ
  } agc_state_t;

  // Magnitude that stays representable: the most negative code folds to full scale.
  function automatic sample_t abs_mag(input sample_t s);
    sample_t r;
    if (!s[WIDTH-1]) begin
      r = s;
    end else if (s == {1'b1, {(WIDTH-1){1'b0}}}) begin
      r = {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      r = -s;
    end
    return r;
  endfunction

endpackage

// File: rtl/tx_agc_if.sv
// Sample bus between the mode mux, the AGC and the i2s transmitter.
interface tx_agc_if;
  import tx_agc_pkg::*;

  logic    next_lrclk_fall;
  logic    i_enable;
  sample_t i_left;
  sample_t i_right;
  sample_t o_left;
  sample_t o_right;
  logic    o_valid;
  gain_t   o_gain;
  logic    o_clip;
  logic    o_overrun;

  modport master (
    output next_lrclk_fall, i_enable, i_left, i_right,
    input  o_left, o_right, o_valid, o_gain, o_clip, o_overrun
  );

  modport slave (
    input  next_lrclk_fall, i_enable, i_left, i_right,
    output o_left, o_right, o_valid, o_gain, o_clip, o_overrun
  );
endinterface

// File: rtl/agc_sat_mul.sv
// One channel of gain scaling: registered signed product, then combinational
// round-half-up, saturation to the sample range and a clip flag.
module agc_sat_mul
  import tx_agc_pkg::*;
(
  input  logic    mclk,
  input  logic    reset_n,
  input  logic    mul_en,
  input  sample_t smp,
  input  gain_t   gain,
  output sample_t res,
  output logic    clip
);

  localparam int PROD_W = WIDTH + GAIN_W + 1;
  localparam int SCL_W  = PROD_W - GAIN_FRAC;

  localparam logic signed [PROD_W-1:0] RND =
    {{(PROD_W-GAIN_FRAC){1'b0}}, 1'b1, {(GAIN_FRAC-1){1'b0}}};
  localparam logic signed [SCL_W-1:0] SAT_HI =
    {{(SCL_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SCL_W-1:0] SAT_LO =
    {{(SCL_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic signed [PROD_W-1:0] smp_x, gain_x, rounded;
  logic signed [SCL_W-1:0]  scaled;

  always_comb begin
    smp_x  = {{(GAIN_W+1){smp[WIDTH-1]}}, smp};
    gain_x = {{(WIDTH+1){1'b0}}, gain};
    prod_d = prod_q;
    if (mul_en) begin
      prod_d = smp_x * gain_x;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  always_comb begin
    rounded = prod_q + RND;
    scaled  = rounded[PROD_W-1:GAIN_FRAC];
    res     = scaled[WIDTH-1:0];
    clip    = 1'b0;
    if (scaled > SAT_HI) begin
      res  = {1'b0, {(WIDTH-1){1'b1}}};
      clip = 1'b1;
    end else if (scaled < SAT_LO) begin
      res  = {1'b1, {(WIDTH-1){1'b0}}};
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/tx_agc.sv
// Per-frame stereo AGC/limiter: capture, multiply, saturate, then adapt gain
// (fast attack on loud/clipped frames, slow recovery after a quiet hold period).
module tx_agc
  import tx_agc_pkg::*;
#(
  parameter gain_t   GAIN_INIT    = 16'd4096,
  parameter gain_t   GAIN_MIN     = 16'd256,
  parameter gain_t   GAIN_MAX     = 16'd16384,
  parameter sample_t HI_THRESH    = 24'h600000,
  parameter sample_t LO_THRESH    = 24'h200000,
  parameter int      ATTACK_SHIFT = 4,
  parameter int      DECAY_SHIFT  = 8,
  parameter int      HOLD_FRAMES  = 480
) (
  input  logic   mclk,
  input  logic   reset_n,
  tx_agc_if.slave bus
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  agc_state_t        state_d, state_q;
  sample_t           smp_l_d, smp_l_q, smp_r_d, smp_r_q;
  gain_t             g_d, g_q, gain_d, gain_q;
  logic              en_d, en_q;
  sample_t           o_left_d, o_left_q, o_right_d, o_right_q;
  logic              o_valid_d, o_valid_q, o_clip_d, o_clip_q;
  logic              o_overrun_d, o_overrun_q;
  logic [HOLD_W-1:0] hold_d, hold_q, hold_inc;

  sample_t           sat_l, sat_r, peak, pk_l, pk_r;
  logic              clip_l, clip_r, mul_en;
  logic [GAIN_W:0]   atk_step, dec_step, gain_dn, gain_up;

  assign mul_en = (state_q == ST_MUL);

  agc_sat_mul u_mul_l (
    .mclk    (mclk),
    .reset_n (reset_n),
    .mul_en  (mul_en),
    .smp     (smp_l_q),
    .gain    (g_q),
    .res     (sat_l),
    .clip    (clip_l)
  );

  agc_sat_mul u_mul_r (
    .mclk    (mclk),
    .reset_n (reset_n),
    .mul_en  (mul_en),
    .smp     (smp_r_q),
    .gain    (g_q),
    .res     (sat_r),
    .clip    (clip_r)
  );

  // Candidate gain moves, evaluated every cycle and picked up in ADJ.
  always_comb begin
    pk_l     = abs_mag(o_left_q);
    pk_r     = abs_mag(o_right_q);
    peak     = (pk_l > pk_r) ? pk_l : pk_r;
    hold_inc = hold_q + 1'b1;

    atk_step = {1'b0, gain_q >> ATTACK_SHIFT};
    if (atk_step == '0) atk_step = (GAIN_W+1)'(1);
    gain_dn = {1'b0, gain_q} - atk_step;
    if (gain_dn < {1'b0, GAIN_MIN}) gain_dn = {1'b0, GAIN_MIN};

    dec_step = {1'b0, gain_q >> DECAY_SHIFT};
    if (dec_step == '0) dec_step = (GAIN_W+1)'(1);
    gain_up = {1'b0, gain_q} + dec_step;
    if (gain_up > {1'b0, GAIN_MAX}) gain_up = {1'b0, GAIN_MAX};
  end

  always_comb begin
    state_d     = state_q;
    smp_l_d     = smp_l_q;
    smp_r_d     = smp_r_q;
    g_d         = g_q;
    en_d        = en_q;
    gain_d      = gain_q;
    hold_d      = hold_q;
    o_left_d    = o_left_q;
    o_right_d   = o_right_q;
    o_clip_d    = o_clip_q;
    o_valid_d   = 1'b0;
    o_overrun_d = o_overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.next_lrclk_fall) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        smp_l_d = bus.i_left;
        smp_r_d = bus.i_right;
        en_d    = bus.i_enable;
        g_d     = bus.i_enable ? gain_q : GAIN_UNITY;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        state_d = ST_SAT;
      end
      ST_SAT: begin
        o_left_d  = sat_l;
        o_right_d = sat_r;
        o_clip_d  = clip_l | clip_r;
        o_valid_d = 1'b1;
        state_d   = ST_ADJ;
      end
      ST_ADJ: begin
        if (en_q) begin
          if (peak > HI_THRESH || o_clip_q) begin
            gain_d = gain_dn[GAIN_W-1:0];
            hold_d = '0;
          end else if (peak < LO_THRESH) begin
            if (hold_inc == HOLD_W'(HOLD_FRAMES)) begin
              gain_d = gain_up[GAIN_W-1:0];
              hold_d = '0;
            end else begin
              hold_d = hold_inc;
            end
          end else begin
            hold_d = '0;
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.next_lrclk_fall && state_q != ST_IDLE) o_overrun_d = 1'b1;
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      smp_l_q     <= '0;
      smp_r_q     <= '0;
      g_q         <= GAIN_UNITY;
      en_q        <= 1'b0;
      gain_q      <= GAIN_INIT;
      hold_q      <= '0;
      o_left_q    <= '0;
      o_right_q   <= '0;
      o_clip_q    <= 1'b0;
      o_valid_q   <= 1'b0;
      o_overrun_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      smp_l_q     <= smp_l_d;
      smp_r_q     <= smp_r_d;
      g_q         <= g_d;
      en_q        <= en_d;
      gain_q      <= gain_d;
      hold_q      <= hold_d;
      o_left_q    <= o_left_d;
      o_right_q   <= o_right_d;
      o_clip_q    <= o_clip_d;
      o_valid_q   <= o_valid_d;
      o_overrun_q <= o_overrun_d;
    end
  end

  assign bus.o_left    = o_left_q;
  assign bus.o_right   = o_right_q;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_gain    = gain_q;
  assign bus.o_clip    = o_clip_q;
  assign bus.o_overrun = o_overrun_q;

endmodule
